// File: rtl/logic_gate_pipe_if.sv
// Handshake bundle for logic_gate_pipe: operand-side valid/ready, result-side
// valid/ready, plus the completed-transfer counter.
interface logic_gate_pipe_if #(
  parameter int WIDTH = 8,
  parameter int NIN   = 2
);
  logic                   in_valid;
  logic                   in_ready;
  logic [NIN*WIDTH-1:0]   in_data;
  logic [2:0]             in_op;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   out_err;
  logic [15:0]            xfer_cnt;

  modport slave (
    input  in_valid, in_data, in_op, out_ready,
    output in_ready, out_valid, out_data, out_err, xfer_cnt
  );

  modport master (
    output in_valid, in_data, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_err, xfer_cnt
  );
endinterface

// File: rtl/logic_gate_pipe.sv
// Two-stage bitwise reduction pipe: S1 registers the operand set, S2 registers
// the reduced result. Each stage has its own valid bit; backpressure ripples back.
module logic_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int NIN   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  logic_gate_pipe_if.slave  bus
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_INV  = 3'd6;

  logic                 r_s1_valid;
  logic [NIN*WIDTH-1:0] r_s1_data;
  logic [2:0]           r_s1_op;
  logic                 r_s2_valid;
  logic [WIDTH-1:0]     r_s2_data;
  logic                 r_s2_err;
  logic [15:0]          r_xfer_cnt;

  logic                 w_in_xfer;
  logic                 w_out_xfer;
  logic                 w_s2_load;
  logic [WIDTH-1:0]     w_lane [NIN];
  logic [WIDTH-1:0]     w_and;
  logic [WIDTH-1:0]     w_or;
  logic [WIDTH-1:0]     w_xor;
  logic [WIDTH-1:0]     w_result;
  logic                 w_err;

  genvar gi;
  generate
    for (gi = 0; gi < NIN; gi++) begin : g_lane
      assign w_lane[gi] = r_s1_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  always_comb begin
    w_and = w_lane[0];
    w_or  = w_lane[0];
    w_xor = w_lane[0];
    for (int k = 1; k < NIN; k++) begin
      w_and = w_and & w_lane[k];
      w_or  = w_or  | w_lane[k];
      w_xor = w_xor ^ w_lane[k];
    end
  end

  always_comb begin
    w_result = '0;
    w_err    = 1'b0;
    case (r_s1_op)
      OP_AND:  w_result = w_and;
      OP_NAND: w_result = ~w_and;
      OP_OR:   w_result = w_or;
      OP_NOR:  w_result = ~w_or;
      OP_XOR:  w_result = w_xor;
      OP_XNOR: w_result = ~w_xor;
      OP_INV:  w_result = ~w_lane[0];
      default: w_err    = 1'b1;
    endcase
  end

  // S1 may refill in the same cycle it hands off, so a full draining pipe never bubbles.
  assign w_s2_load    = r_s1_valid && (!r_s2_valid || bus.out_ready);
  assign bus.in_ready = rst_n && (!r_s1_valid || !r_s2_valid || bus.out_ready);
  assign w_in_xfer    = bus.in_valid && bus.in_ready;
  assign w_out_xfer   = r_s2_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_op    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_err   <= 1'b0;
      r_xfer_cnt <= '0;
    end else begin
      if (w_in_xfer) begin
        r_s1_valid <= 1'b1;
        r_s1_data  <= bus.in_data;
        r_s1_op    <= bus.in_op;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s2_load) begin
        r_s2_valid <= 1'b1;
        r_s2_data  <= w_result;
        r_s2_err   <= w_err;
      end else if (w_out_xfer) begin
        r_s2_valid <= 1'b0;
      end

      if (w_out_xfer) begin
        r_xfer_cnt <= r_xfer_cnt + 16'd1;
      end
    end
  end

  assign bus.out_valid = r_s2_valid;
  assign bus.out_data  = r_s2_data;
  assign bus.out_err   = r_s2_err;
  assign bus.xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed bench for logic_gate_pipe: a 2-lane and a 3-lane instance share the
// clock and reset; a queue scoreboard per instance tracks expected results.
module tb_logic_gate_pipe;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic_gate_pipe_if #(.WIDTH(8), .NIN(2)) if2 ();
  logic_gate_pipe_if #(.WIDTH(8), .NIN(3)) if3 ();

  logic_gate_pipe #(.WIDTH(8), .NIN(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  logic_gate_pipe #(.WIDTH(8), .NIN(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  exp_t        q2[$];
  exp_t        q3[$];
  logic [15:0] m_cnt2 = 16'd0;
  logic [15:0] m_cnt3 = 16'd0;
  int          n_assert = 0;
  int          n_fail = 0;
  bit          verbose = 1'b1;

  function automatic exp_t model(logic [23:0] d, logic [2:0] op, int n);
    logic [7:0] a, o, x, lane;
    exp_t r;
    a = 8'hFF; o = 8'h00; x = 8'h00;
    for (int k = 0; k < n; k++) begin
      lane = d[k*8 +: 8];
      a = a & lane;
      o = o | lane;
      x = x ^ lane;
    end
    r.err = 1'b0;
    case (op)
      3'd0: r.data = a;
      3'd1: r.data = ~a;
      3'd2: r.data = o;
      3'd3: r.data = ~o;
      3'd4: r.data = x;
      3'd5: r.data = ~x;
      3'd6: r.data = ~d[7:0];
      default: begin r.data = 8'h00; r.err = 1'b1; end
    endcase
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Transfers are judged on the settled signals at the negedge before the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      q2.delete(); q3.delete();
      m_cnt2 = 16'd0; m_cnt3 = 16'd0;
      chk("rst_in_ready2", if2.in_ready, 1'b0);
      chk("rst_in_ready3", if3.in_ready, 1'b0);
    end else begin
      if (if3.out_valid && if3.out_ready) begin
        if (q3.size() == 0) chk("spurious_out3", 1'b1, 1'b0);
        else begin
          e = q3.pop_front();
          chk("sb_data3", if3.out_data, e.data);
          chk("sb_err3", if3.out_err, e.err);
        end
        m_cnt3 = m_cnt3 + 16'd1;
        if (verbose) $display("dut3 out data=%h err=%b cnt=%0d", if3.out_data, if3.out_err, m_cnt3);
      end
      if (if3.in_valid && if3.in_ready) begin
        q3.push_back(model(if3.in_data, if3.in_op, 3));
        if (verbose) $display("dut3 in  data=%h op=%0d", if3.in_data, if3.in_op);
      end
      if (if2.out_valid && if2.out_ready) begin
        if (q2.size() == 0) chk("spurious_out2", 1'b1, 1'b0);
        else begin
          e = q2.pop_front();
          chk("sb_data2", if2.out_data, e.data);
          chk("sb_err2", if2.out_err, e.err);
        end
        m_cnt2 = m_cnt2 + 16'd1;
        if (verbose) $display("dut2 out data=%h err=%b cnt=%0d", if2.out_data, if2.out_err, m_cnt2);
      end
      if (if2.in_valid && if2.in_ready) begin
        q2.push_back(model({8'h00, if2.in_data}, if2.in_op, 2));
        if (verbose) $display("dut2 in  data=%h op=%0d", if2.in_data, if2.in_op);
      end
    end
    @(posedge clk);
    #1;
    chk("xfer_cnt3", if3.xfer_cnt, m_cnt3);
    chk("xfer_cnt2", if2.xfer_cnt, m_cnt2);
  endtask

  task automatic drain();
    if2.in_valid = 1'b0; if3.in_valid = 1'b0;
    if2.out_ready = 1'b1; if3.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("drain_q3", q3.size(), 0);
    chk("drain_q2", q2.size(), 0);
  endtask

  initial begin
    logic [23:0] pats [3];
    logic [15:0] wrap_exp [3];
    pats[0] = 24'hAA0FFF; pats[1] = 24'hF03CFF; pats[2] = 24'h5A5AA5;
    wrap_exp[0] = 16'hFFFF; wrap_exp[1] = 16'h0000; wrap_exp[2] = 16'h0001;

    if2.in_valid = 1'b0; if2.in_data = '0; if2.in_op = '0; if2.out_ready = 1'b0;
    if3.in_valid = 1'b0; if3.in_data = '0; if3.in_op = '0; if3.out_ready = 1'b0;

    // Reset state
    rst_n = 1'b0;
    step(); step();
    chk("rst_out_valid3", if3.out_valid, 1'b0);
    chk("rst_out_data3", if3.out_data, 8'h00);
    chk("rst_out_err3", if3.out_err, 1'b0);
    chk("rst_in_ready_low", if3.in_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready3", if3.in_ready, 1'b1);
    chk("post_rst_in_ready2", if2.in_ready, 1'b1);

    // NAND on 2 lanes, 2-cycle latency
    if2.out_ready = 1'b1; if3.out_ready = 1'b1;
    if2.in_valid = 1'b1; if2.in_data = {8'hF0, 8'h3C}; if2.in_op = 3'd1;
    step();
    if2.in_valid = 1'b0;
    chk("lat_cycle1_valid", if2.out_valid, 1'b0);
    step();
    chk("lat_cycle2_valid", if2.out_valid, 1'b1);
    chk("nand_data", if2.out_data, 8'hCF);
    chk("nand_err", if2.out_err, 1'b0);
    step();

    // XOR then NOR back to back on 3 lanes
    if3.in_valid = 1'b1; if3.in_data = {8'hAA, 8'h0F, 8'hFF}; if3.in_op = 3'd4;
    step();
    if3.in_op = 3'd3;
    step();
    if3.in_valid = 1'b0;
    chk("xor_valid", if3.out_valid, 1'b1);
    chk("xor_data", if3.out_data, 8'h5A);
    step();
    chk("nor_valid", if3.out_valid, 1'b1);
    chk("nor_data", if3.out_data, 8'h00);
    step();

    // Reserved opcode, then AND clears the error flag
    if3.in_valid = 1'b1; if3.in_data = 24'h123456; if3.in_op = 3'd7;
    step();
    if3.in_data = {8'hFF, 8'hF0, 8'h3C}; if3.in_op = 3'd0;
    step();
    if3.in_valid = 1'b0;
    chk("rsv_data", if3.out_data, 8'h00);
    chk("rsv_err", if3.out_err, 1'b1);
    step();
    chk("and_after_rsv_data", if3.out_data, 8'h30);
    chk("and_after_rsv_err", if3.out_err, 1'b0);
    drain();

    // Every opcode over several patterns with random backpressure
    for (int op = 0; op < 8; op++) begin
      for (int p = 0; p < 3; p++) begin
        if3.in_valid = 1'b1; if3.in_data = pats[p]; if3.in_op = 3'(op);
        if2.in_valid = 1'b1; if2.in_data = pats[p][15:0]; if2.in_op = 3'(op);
        if3.out_ready = 1'($urandom_range(0, 1));
        if2.out_ready = 1'($urandom_range(0, 1));
        for (int t = 0; t < 10 && !(if3.in_ready && if2.in_ready); t++) step();
        step();
      end
    end
    drain();

    // Backpressure: only two sets fit, results emerge in order
    if3.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if3.in_valid = 1'b1; if3.in_data = 24'(32'h00111111 * (i + 1)); if3.in_op = 3'(i);
      step();
      if (if3.out_valid) chk("stall_hold_data", if3.out_data, q3[0].data);
    end
    if3.in_valid = 1'b0;
    chk("stall_accepted", q3.size(), 2);
    chk("stall_in_ready", if3.in_ready, 1'b0);
    chk("stall_out_valid", if3.out_valid, 1'b1);
    if3.out_ready = 1'b1;
    step(); step();
    chk("stall_drained", q3.size(), 0);
    chk("stall_in_ready_after", if3.in_ready, 1'b1);
    drain();

    // Counter wrap
    verbose = 1'b0;
    if3.in_valid = 1'b1; if3.out_ready = 1'b1;
    for (int i = 0; i < 70000 && m_cnt3 != 16'hFFFE; i++) begin
      if3.in_data = 24'($urandom); if3.in_op = 3'($urandom);
      step();
    end
    chk("cnt_preload", if3.xfer_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("cnt_wrap", if3.xfer_cnt, wrap_exp[i]);
    end
    verbose = 1'b1;
    drain();

    // Reset with two sets in flight
    if3.out_ready = 1'b0;
    if3.in_valid = 1'b1; if3.in_data = 24'hFFFFFF; if3.in_op = 3'd0;
    step(); step();
    chk("inflight_count", q3.size(), 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", if3.in_ready, 1'b0);
    step();
    chk("mid_rst_out_valid", if3.out_valid, 1'b0);
    chk("mid_rst_xfer_cnt", if3.xfer_cnt, 16'h0000);
    rst_n = 1'b1;
    if3.in_valid = 1'b0; if3.out_ready = 1'b1;
    #1;
    chk("after_rst_in_ready", if3.in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_stale_out", if3.out_valid, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
